// File: rtl/data_mem_responder_pkg.sv
// Shared register map for the data-memory responder: MMIO offsets and timer bit
// positions as macros, plus the typed view of them used by the RTL.
`ifndef DATA_MEM_RESPONDER_DEFINES
`define DATA_MEM_RESPONDER_DEFINES
`define MMIO_OFF_GPIO_OUT   4'd0
`define MMIO_OFF_GPIO_IN    4'd1
`define MMIO_OFF_TMR_CNT    4'd2
`define MMIO_OFF_TMR_CMP    4'd3
`define MMIO_OFF_TMR_STAT   4'd4
`define MMIO_OFF_TMR_CTRL   4'd5
`define TMR_STAT_MATCH_BIT  0
`define TMR_CTRL_EN_BIT     0
`define TMR_CTRL_PRESC_LSB  4
`define TMR_CTRL_PRESC_MSB  7
`endif

package data_mem_responder_pkg;

    typedef enum logic [3:0] {
        REG_GPIO_OUT  = `MMIO_OFF_GPIO_OUT,
        REG_GPIO_IN   = `MMIO_OFF_GPIO_IN,
        REG_TMR_CNT   = `MMIO_OFF_TMR_CNT,
        REG_TMR_CMP   = `MMIO_OFF_TMR_CMP,
        REG_TMR_STAT  = `MMIO_OFF_TMR_STAT,
        REG_TMR_CTRL  = `MMIO_OFF_TMR_CTRL
    } mmio_reg_e;

    localparam int PRESC_WIDTH = `TMR_CTRL_PRESC_MSB - `TMR_CTRL_PRESC_LSB + 1;

    // The MMIO window occupies the top 16 addresses of the data space.
    function automatic int mmio_base(input int addr_width);
        return (1 << addr_width) - 16;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Prescaled up-counter with compare-match flag; the flag doubles as the level IRQ.
module mmio_timer
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  cmp_we,
    input  logic                  stat_we,
    input  logic                  ctrl_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] cnt,
    output logic [DATA_WIDTH-1:0] cmp,
    output logic [DATA_WIDTH-1:0] stat,
    output logic [DATA_WIDTH-1:0] ctrl,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0]  cnt_reg;
    logic [DATA_WIDTH-1:0]  cmp_reg;
    logic [DATA_WIDTH-1:0]  ctrl_reg;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic                   match_reg;
    logic [DATA_WIDTH-1:0]  cnt_next;
    logic                   enable;
    logic                   tick;
    logic                   match;

    assign enable   = ctrl_reg[`TMR_CTRL_EN_BIT];
    assign tick     = enable && (presc_reg == ctrl_reg[`TMR_CTRL_PRESC_MSB:`TMR_CTRL_PRESC_LSB]);
    assign cnt_next = cnt_reg + DATA_WIDTH'(1);
    // Match is judged against the compare value in force before this edge,
    // so rewriting CMP never raises the flag by itself.
    assign match    = tick && (cnt_next == cmp_reg);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_reg   <= '0;
            cmp_reg   <= '1;
            ctrl_reg  <= '0;
            presc_reg <= '0;
            match_reg <= 1'b0;
        end else begin
            if (tick) begin
                cnt_reg <= cnt_next;
            end
            if (enable) begin
                presc_reg <= tick ? '0 : presc_reg + PRESC_WIDTH'(1);
            end
            if (ctrl_we) begin
                ctrl_reg <= wdata;
                if (!wdata[`TMR_CTRL_EN_BIT]) begin
                    presc_reg <= '0;
                end
            end
            if (cmp_we) begin
                cmp_reg <= wdata;
            end
            // Later assignment wins: a match on the same edge beats the W1C.
            if (stat_we && wdata[`TMR_STAT_MATCH_BIT]) begin
                match_reg <= 1'b0;
            end
            if (match) begin
                match_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        stat = '0;
        stat[`TMR_STAT_MATCH_BIT] = match_reg;
    end

    assign cnt  = cnt_reg;
    assign cmp  = cmp_reg;
    assign ctrl = ctrl_reg;
    assign irq  = match_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: RAM below MMIO_BASE, GPIO and (with MMIO_TIMER_EN defined)
// a prescaled timer in the top 16 addresses. Reads are zero-wait combinational.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
    input  logic                      mem_WE,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
    input  logic [MEM_DATA_WIDTH-1:0] gpio_in,
    output logic [MEM_DATA_WIDTH-1:0] gpio_out,
    output logic                      timer_irq
);

    localparam int MMIO_BASE = mmio_base(MEM_ADDR_WIDTH);

    logic [MEM_DATA_WIDTH-1:0] ram [0:MMIO_BASE-1];
    logic [MEM_DATA_WIDTH-1:0] gpio_out_reg;
    logic [MEM_DATA_WIDTH-1:0] gpio_sync1_reg;
    logic [MEM_DATA_WIDTH-1:0] gpio_sync2_reg;
    logic                      is_mmio;
    logic                      mmio_we;
    mmio_reg_e                 mmio_reg;

    // Address is in the MMIO window exactly when all bits above the offset are set.
    assign is_mmio  = &mem_addr[MEM_ADDR_WIDTH-1:4];
    assign mmio_reg = mmio_reg_e'(mem_addr[3:0]);
    assign mmio_we  = mem_WE && is_mmio;

    // RAM is never cleared, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_WE && !is_mmio && !arst) begin
            ram[mem_addr] <= mem_data_i;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            gpio_out_reg   <= '0;
            gpio_sync1_reg <= '0;
            gpio_sync2_reg <= '0;
        end else begin
            gpio_sync1_reg <= gpio_in;
            gpio_sync2_reg <= gpio_sync1_reg;
            if (mmio_we && mmio_reg == REG_GPIO_OUT) begin
                gpio_out_reg <= mem_data_i;
            end
        end
    end

    assign gpio_out = gpio_out_reg;

`ifdef MMIO_TIMER_EN
    logic [MEM_DATA_WIDTH-1:0] tmr_cnt;
    logic [MEM_DATA_WIDTH-1:0] tmr_cmp;
    logic [MEM_DATA_WIDTH-1:0] tmr_stat;
    logic [MEM_DATA_WIDTH-1:0] tmr_ctrl;

    mmio_timer #(
        .DATA_WIDTH (MEM_DATA_WIDTH)
    ) u_timer (
        .clk     (clk),
        .arst    (arst),
        .cmp_we  (mmio_we && mmio_reg == REG_TMR_CMP),
        .stat_we (mmio_we && mmio_reg == REG_TMR_STAT),
        .ctrl_we (mmio_we && mmio_reg == REG_TMR_CTRL),
        .wdata   (mem_data_i),
        .cnt     (tmr_cnt),
        .cmp     (tmr_cmp),
        .stat    (tmr_stat),
        .ctrl    (tmr_ctrl),
        .irq     (timer_irq)
    );
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        mem_data_o = '0;
        if (!is_mmio) begin
            mem_data_o = ram[mem_addr];
        end else begin
            case (mmio_reg)
                REG_GPIO_OUT: mem_data_o = gpio_out_reg;
                REG_GPIO_IN:  mem_data_o = gpio_sync2_reg;
`ifdef MMIO_TIMER_EN
                REG_TMR_CNT:  mem_data_o = tmr_cnt;
                REG_TMR_CMP:  mem_data_o = tmr_cmp;
                REG_TMR_STAT: mem_data_o = tmr_stat;
                REG_TMR_CTRL: mem_data_o = tmr_ctrl;
`endif
                default:      mem_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_data_mem_responder;

    localparam int SEL_RDATA = 0;
    localparam int SEL_GPIO  = 1;
    localparam int SEL_IRQ   = 2;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] mem_addr = 8'h00;
    logic [7:0] mem_data_i = 8'h00;
    logic       mem_WE = 1'b0;
    logic [7:0] mem_data_o;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out;
    logic       timer_irq;

    data_mem_responder #(
        .MEM_ADDR_WIDTH (8),
        .MEM_DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .mem_addr   (mem_addr),
        .mem_data_i (mem_data_i),
        .mem_WE     (mem_WE),
        .mem_data_o (mem_data_o),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] mon_act;
    int checks = 0;
    int errors = 0;

    // Monitor: mid-cycle, compare every expectation queued since the last edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.sel)
                SEL_RDATA: mon_act = mem_data_o;
                SEL_GPIO:  mon_act = gpio_out;
                default:   mon_act = {7'b0, timer_irq};
            endcase
            checks++;
            if (mon_act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: actual 0x%02h required 0x%02h", mon_e.name, mon_act, mon_e.exp);
            end else begin
                $display("ok   %s: 0x%02h", mon_e.name, mon_act);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int sel, input logic [7:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] val, input string name);
        mem_WE   = 1'b0;
        mem_addr = a;
        expect_out(SEL_RDATA, val, name);
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        mem_addr   = a;
        mem_data_i = d;
        mem_WE     = 1'b1;
        step();
        mem_WE     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while arst is held; gpio_in toggling must not reach the syncs.
        gpio_in = 8'hFF;
        step();
        step();
        expect_out(SEL_GPIO, 8'h00, "rst_gpio_out");
        expect_out(SEL_IRQ, 8'h00, "rst_timer_irq");
        rd(8'hF0, 8'h00, "rst_gpio_out_rd");
        rd(8'hF1, 8'h00, "rst_gpio_in_sync");
        rd(8'hF2, 8'h00, "rst_tmr_cnt");
`ifdef MMIO_TIMER_EN
        rd(8'hF3, 8'hFF, "rst_tmr_cmp");
`else
        rd(8'hF3, 8'h00, "rst_tmr_cmp_absent");
`endif
        rd(8'hF4, 8'h00, "rst_tmr_stat");
        rd(8'hF5, 8'h00, "rst_tmr_ctrl");
        gpio_in = 8'h00;
        arst = 1'b0;
        step();
        step();
        step();

        // RAM write then zero-wait read, boundaries 0x00 and 0xEF
        wr(8'h10, 8'h5A);
        rd(8'h10, 8'h5A, "ram_rd_10");
        wr(8'hEF, 8'hA5);
        wr(8'h00, 8'h11);
        rd(8'hEF, 8'hA5, "ram_rd_ef");
        rd(8'h00, 8'h11, "ram_rd_00");
        rd(8'h10, 8'h5A, "ram_rd_10_again");

        // GPIO_OUT, reserved and read-only offsets
        wr(8'hF0, 8'hC3);
        expect_out(SEL_GPIO, 8'hC3, "gpio_out_after_wr");
        rd(8'hF0, 8'hC3, "gpio_out_rd");
        wr(8'hF8, 8'h77);
        rd(8'hF8, 8'h00, "reserved_f8_rd");
        wr(8'hF1, 8'h55);
        rd(8'hF1, 8'h00, "gpio_in_ro");
        expect_out(SEL_GPIO, 8'hC3, "gpio_out_held");

        // Two-flop synchroniser latency
        gpio_in = 8'h81;
        rd(8'hF1, 8'h00, "gpio_in_edge0");
        rd(8'hF1, 8'h00, "gpio_in_edge1");
        rd(8'hF1, 8'h81, "gpio_in_edge2");

`ifdef MMIO_TIMER_EN
        // Prescale 0: count every cycle, match at 3
        wr(8'hF3, 8'h03);
        wr(8'hF5, 8'h01);
        expect_out(SEL_IRQ, 8'h00, "irq_cnt0");
        rd(8'hF2, 8'h00, "tmr_cnt0");
        expect_out(SEL_IRQ, 8'h00, "irq_cnt1");
        rd(8'hF2, 8'h01, "tmr_cnt1");
        expect_out(SEL_IRQ, 8'h00, "irq_cnt2");
        rd(8'hF2, 8'h02, "tmr_cnt2");
        expect_out(SEL_IRQ, 8'h01, "irq_match3");
        rd(8'hF4, 8'h01, "stat_match3");
        // W1C clears, then W1C on the match edge loses to the set
        wr(8'hF4, 8'h01);
        expect_out(SEL_IRQ, 8'h00, "irq_cleared");
        rd(8'hF4, 8'h00, "stat_cleared");
        wr(8'hF3, 8'h08);
        wr(8'hF4, 8'h01);
        expect_out(SEL_IRQ, 8'h01, "irq_set_wins");
        rd(8'hF4, 8'h01, "stat_set_wins");
        wr(8'hF4, 8'h01);
        rd(8'hF4, 8'h00, "stat_cleared_again");
        // Disable holds count; prescale 2 counts every 3 cycles
        wr(8'hF5, 8'h00);
        rd(8'hF2, 8'h0C, "tmr_hold_a");
        rd(8'hF2, 8'h0C, "tmr_hold_b");
        wr(8'hF5, 8'h21);
        rd(8'hF2, 8'h0C, "presc_p0");
        rd(8'hF2, 8'h0C, "presc_p1");
        rd(8'hF2, 8'h0C, "presc_p2");
        rd(8'hF2, 8'h0D, "presc_inc1_p0");
        rd(8'hF2, 8'h0D, "presc_inc1_p1");
        rd(8'hF2, 8'h0D, "presc_inc1_p2");
        rd(8'hF2, 8'h0E, "presc_inc2");
        rd(8'hF5, 8'h21, "tmr_ctrl_rd");
        rd(8'hF4, 8'h00, "stat_no_spurious");
`else
        // Timer absent: its offsets read 0 and writes are ignored
        wr(8'hF3, 8'h03);
        wr(8'hF5, 8'h01);
        rd(8'hF2, 8'h00, "no_tmr_cnt");
        rd(8'hF3, 8'h00, "no_tmr_cmp");
        rd(8'hF4, 8'h00, "no_tmr_stat");
        rd(8'hF5, 8'h00, "no_tmr_ctrl");
        expect_out(SEL_IRQ, 8'h00, "no_tmr_irq");
        step();
`endif

        // Async reset mid-cycle during a GPIO_OUT write pulse, then a RAM write
        mem_addr   = 8'hF0;
        mem_data_i = 8'h3C;
        mem_WE     = 1'b1;
        #1;
        arst = 1'b1;
        #1;
        expect_out(SEL_GPIO, 8'h00, "arst_gpio_out_now");
        expect_out(SEL_IRQ, 8'h00, "arst_irq_now");
        expect_out(SEL_RDATA, 8'h00, "arst_gpio_rd_now");
        step();
        mem_addr   = 8'h10;
        mem_data_i = 8'hEE;
        mem_WE     = 1'b1;
        expect_out(SEL_GPIO, 8'h00, "arst_gpio_out_not_written");
        expect_out(SEL_RDATA, 8'h5A, "arst_ram_kept");
        step();
        mem_WE = 1'b0;
        arst   = 1'b0;
        rd(8'h10, 8'h5A, "arst_ram_write_aborted");
        rd(8'hF0, 8'h00, "arst_gpio_out_rd");
        rd(8'hF2, 8'h00, "arst_tmr_cnt");
`ifdef MMIO_TIMER_EN
        rd(8'hF3, 8'hFF, "arst_tmr_cmp");
`endif
        rd(8'hF5, 8'h00, "arst_tmr_ctrl");
        expect_out(SEL_IRQ, 8'h00, "arst_irq");
        step();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            step();
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0 pending", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 8, data-memory address width.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 8, data word width; GPIO width equals it.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mem_addr  input  MEM_ADDR_WIDTH  address from the core's MAR.
REQ-006 SHALL have port mem_data_i  input  MEM_DATA_WIDTH  write data from the core.
REQ-007 SHALL have port mem_WE  input  1  write enable; one-cycle pulse per write.
REQ-008 SHALL have port mem_data_o  output  MEM_DATA_WIDTH  read data to the core.
REQ-009 SHALL have port gpio_in  input  MEM_DATA_WIDTH  asynchronous external inputs.
REQ-010 SHALL have port gpio_out  output  MEM_DATA_WIDTH  registered external outputs.
REQ-011 SHALL have port timer_irq  output  1  level copy of the timer match flag.

Function
REQ-012 SHALL decode MMIO_BASE = 2**MEM_ADDR_WIDTH-16; addresses below it map to RAM (0x00-0xEF at default width).
REQ-013 SHALL provide an MMIO map at offsets from MMIO_BASE: +0 GPIO_OUT rw, +1 GPIO_IN ro, +2 TMR_CNT ro, +3 TMR_CMP rw, +4 TMR_STAT w1c, +5 TMR_CTRL rw; +6..+15 read 0, writes ignored.
REQ-014 SHALL drive mem_data_o combinationally from mem_addr and current storage contents (zero-wait read: address valid one cycle, data sampled by the core at that cycle's end).
REQ-015 SHALL commit a write at the rising edge where mem_WE=1, using mem_addr and mem_data_i of that cycle; writes to ro registers are ignored.
REQ-016 SHALL return, for a read of an address written in the previous cycle, the new value (no read-old hazard).
REQ-017 SHALL synchronise gpio_in through two flops; GPIO_IN reads the second stage (2-cycle latency).
REQ-018 SHALL, when TMR_CTRL[0]=1, increment an internal prescale counter each cycle; when it equals TMR_CTRL[7:4] it clears and TMR_CNT increments by 1.
REQ-019 SHALL wrap TMR_CNT from 2**MEM_DATA_WIDTH-1 to 0 with no flag.
REQ-020 SHALL set TMR_STAT[0] on the edge where TMR_CNT increments to a value equal to TMR_CMP; no set when disabled or on CMP writes.
REQ-021 SHALL clear TMR_STAT[0] when written with bit0=1; on the same edge as a set, set wins.
REQ-022 SHALL clear the prescale counter when TMR_CTRL[0] is written 0; TMR_CNT holds its value.

Reset
REQ-023 SHALL on arst set gpio_out=0, sync flops=0, TMR_CNT=0, prescale=0, TMR_CMP=all ones, TMR_STAT=0, TMR_CTRL=0, timer_irq=0.
REQ-024 SHALL leave RAM contents unreset; arst mid-write SHALL abort that write.

Configuration
REQ-025 SHALL with macro MMIO_TIMER_EN defined include timer registers and timer_irq behaviour per REQ-018..022.
REQ-026 SHALL with MMIO_TIMER_EN undefined make +2..+5 read 0, ignore writes, tie timer_irq to 0, and instantiate no timer logic.

Structure
REQ-027 SHALL place MMIO offsets (GPIO_OUT..TMR_CTRL) and TMR_STAT/TMR_CTRL bit positions as macros in the shared defines.v.
REQ-028 SHALL implement the timer as one sub-module, mmio_timer, instantiated only under MMIO_TIMER_EN.

Verification
REQ-029 SHALL cover: write 0x5A to 0x10 (mem_WE one cycle), next cycle address 0x10 -> mem_data_o=0x5A.
REQ-030 SHALL cover: write 0xC3 to 0xF0 -> gpio_out=0xC3 after that edge; read 0xF0 -> 0xC3; write to 0xF8 -> read 0x00.
REQ-031 SHALL cover: gpio_in changes 0x00->0x81 -> GPIO_IN reads 0x00 for 2 edges, then 0x81.
REQ-032 SHALL cover: CMP=0x03, CTRL=0x01 -> STAT[0] and timer_irq rise on the edge TMR_CNT becomes 3; CTRL=0x21 -> TMR_CNT increments every 3 cycles.
REQ-033 SHALL cover: write 0x01 to TMR_STAT on the same edge a match occurs -> flag stays 1; next write clears it.
REQ-034 SHALL cover: arst asserted mid-count and during a mem_WE pulse -> all REQ-023 values immediately, GPIO_OUT not updated.
